// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over req/ack,
// and hands each word to decode over valid/ready, then steers the PC.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        beq,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_idx,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] branch_off;
  logic [31:0] next_pc;
  logic        taken;
  logic        fetch_done;
  logic        handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ack) state_nxt = FULL;
      FULL:    if (instr_ready) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Request and valid come straight from the state register, so instr_ready
  // never reaches imem_req or imem_addr combinationally.
  assign imem_req    = (state == REQ);
  assign instr_valid = (state == FULL);
  assign imem_addr   = pc;
  assign fetch_done  = (state == REQ) && imem_ack;
  assign handshake   = (state == FULL) && instr_ready;

  assign pc4        = pc_out + 32'd4;
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign taken      = (beq & zero) | (bne & ~zero);

  always_comb begin
    next_pc = pc4;
    if (jump)       next_pc = {pc4[31:28], jump_idx, 2'b00};
    else if (taken) next_pc = pc4 + branch_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr       <= 32'd0;
      pc_out      <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (fetch_done) begin
        instr  <= imem_rdata;
        pc_out <= pc;
      end
      if (handshake) begin
        pc          <= next_pc;
        instr_count <= instr_count + 32'd1;
      end
    end
  end

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a transaction-level fetch model
// compared every cycle, directed scenarios with literal addresses, then random traffic.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        beq = 1'b0;
  logic        bne = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [15:0] branch_imm = 16'd0;
  logic [25:0] jump_idx = 26'd0;
  logic [31:0] instr_count;

  int tests = 0;
  int fails = 0;

  int  lat_mode = 1;
  bit  spurious = 1'b0;
  bit  ack_in_reset = 1'b0;
  logic [31:0] addr_q[$];

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct), .pc_out(pc_out),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .beq(beq), .bne(bne), .jump(jump), .zero(zero),
    .branch_imm(branch_imm), .jump_idx(jump_idx),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference next-PC from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] modelNextPc(input logic [31:0] pco, input logic b, input logic n,
                                               input logic j, input logic z,
                                               input logic [15:0] imm, input logic [25:0] idx);
    logic [31:0] p4;
    int off;
    p4 = pco + 32'd4;
    if (j) return (p4 & 32'hF000_0000) + (32'(idx) * 32'd4);
    if ((b && z) || (n && !z)) begin
      off = int'($signed(imm));
      return p4 + 32'(off * 4);
    end
    return p4;
  endfunction

  // Transaction-level model: awaiting word, holding word for decode, or about to fetch.
  logic        m_req;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc_out;
  logic [31:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req <= 1'b0; m_valid <= 1'b0; m_pc <= RPC;
      m_instr <= 32'd0; m_pc_out <= 32'd0; m_count <= 32'd0;
    end else if (m_req) begin
      if (imem_ack) begin
        m_instr <= imem_rdata; m_pc_out <= m_pc; m_valid <= 1'b1; m_req <= 1'b0;
      end
    end else if (m_valid) begin
      if (instr_ready) begin
        m_count <= m_count + 32'd1;
        m_pc    <= modelNextPc(m_pc_out, beq, bne, jump, zero, branch_imm, jump_idx);
        m_valid <= 1'b0;
        m_req   <= 1'b1;
      end
    end else begin
      m_req <= 1'b1;
    end
  end

  always @(negedge clk) begin
    checkOutput("imem_req", 32'(imem_req), 32'(m_req));
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
    checkOutput("instr", instr, m_instr);
    checkOutput("opcode", 32'(opcode), 32'(m_instr[31:26]));
    checkOutput("funct", 32'(funct), 32'(m_instr[5:0]));
    checkOutput("pc_out", pc_out, m_pc_out);
    checkOutput("instr_count", instr_count, m_count);
  end

  // Instruction memory: acks each request after lat_mode wait cycles (random 0..3 if negative).
  initial begin
    int cnt = 0;
    int cur_lat = 1;
    bit busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_ack = ack_in_reset; imem_rdata = $urandom; cnt = 0; busy = 1'b0;
      end else if (imem_req) begin
        if (!busy) begin
          busy = 1'b1; cnt = 0;
          cur_lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        if (cnt >= cur_lat) begin
          imem_ack = 1'b1; imem_rdata = memWord(imem_addr);
          addr_q.push_back(imem_addr); busy = 1'b0;
        end else begin
          imem_ack = 1'b0; imem_rdata = $urandom; cnt++;
        end
      end else begin
        imem_ack = spurious; imem_rdata = $urandom;
      end
    end
  end

  task automatic waitValid();
    int k = 0;
    while (!instr_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (!instr_valid) begin
      fails++;
      $display("[TB] FAIL wait_valid: instr_valid still %b after %0d cycles, required 1", instr_valid, k);
    end
  endtask

  // Waits for a held instruction, then accepts it with the given decode results.
  task automatic applyStimulus(input logic b, input logic n, input logic j, input logic z,
                               input logic [15:0] imm, input logic [25:0] idx);
    waitValid();
    beq = b; bne = n; jump = j; zero = z; branch_imm = imm; jump_idx = idx;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; beq = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
    branch_imm = 16'd0; jump_idx = 26'd0;
  endtask

  initial begin
    logic [31:0] saved_instr;
    logic [31:0] saved_cnt;
    int req_cycles;

    repeat (3) @(negedge clk);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, RPC);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_count", instr_count, 32'd0);
    rst_n = 1'b1;
    checkOutput("req_after_release", 32'(imem_req), 32'd0);

    repeat (3) applyStimulus(0, 0, 0, 0, 16'd0, 26'd0);
    checkOutput("count_after_3", instr_count, 32'd3);
    checkOutput("addr0", addr_q[0], 32'h0040_0000);
    checkOutput("addr1", addr_q[1], 32'h0040_0004);
    checkOutput("addr2", addr_q[2], 32'h0040_0008);
    checkOutput("opcode_field", 32'(opcode), 32'(memWord(32'h0040_0008) >> 26));

    applyStimulus(0, 0, 0, 0, 16'd0, 26'd0);
    waitValid();
    checkOutput("pc_before_beq", pc_out, 32'h0040_0010);
    applyStimulus(1, 0, 0, 1, 16'hFFFF, 26'd0);
    waitValid();
    checkOutput("beq_target", pc_out, 32'h0040_0010);
    applyStimulus(0, 1, 0, 1, 16'hFFFF, 26'd0);
    waitValid();
    checkOutput("bne_not_taken", pc_out, 32'h0040_0014);
    repeat (3) applyStimulus(0, 0, 0, 0, 16'd0, 26'd0);
    waitValid();
    checkOutput("pc_before_jump", pc_out, 32'h0040_0020);
    applyStimulus(1, 0, 1, 1, 16'h0004, 26'h010_0000);
    waitValid();
    checkOutput("jump_wins", pc_out, 32'h0040_0000);

    saved_instr = instr;
    saved_cnt = instr_count;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_instr", instr, saved_instr);
      checkOutput("stall_pc", pc_out, 32'h0040_0000);
      checkOutput("stall_req", 32'(imem_req), 32'd0);
      checkOutput("stall_count", instr_count, saved_cnt);
    end
    lat_mode = 3;
    applyStimulus(0, 0, 0, 0, 16'd0, 26'd0);
    checkOutput("count_after_stall", instr_count, saved_cnt + 32'd1);

    req_cycles = 0;
    while (!instr_valid && req_cycles < 20) begin
      @(negedge clk);
      if (imem_req) req_cycles++;
    end
    checkOutput("lat3_req_cycles", 32'(req_cycles), 32'd3);
    checkOutput("lat3_pc", pc_out, 32'h0040_0004);

    saved_instr = instr;
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("spurious_instr", instr, saved_instr);
    end
    spurious = 1'b0;

    lat_mode = 10;
    applyStimulus(0, 0, 0, 0, 16'd0, 26'd0);
    repeat (2) @(negedge clk);
    ack_in_reset = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_req", 32'(imem_req), 32'd0);
    checkOutput("midreset_addr", imem_addr, RPC);
    checkOutput("midreset_valid", 32'(instr_valid), 32'd0);
    checkOutput("midreset_count", instr_count, 32'd0);
    checkOutput("midreset_pc_out", pc_out, 32'd0);
    repeat (3) @(negedge clk);
    ack_in_reset = 1'b0;
    lat_mode = 1;
    rst_n = 1'b1;
    waitValid();
    checkOutput("refetch_pc", pc_out, RPC);
    checkOutput("refetch_addr", addr_q[$], RPC);
    checkOutput("refetch_count", instr_count, 32'd0);

    lat_mode = -1;
    repeat (400) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 9) < 7);
      beq = 1'($urandom); bne = 1'($urandom); zero = 1'($urandom);
      jump = ($urandom_range(0, 7) == 0);
      branch_imm = 16'($urandom); jump_idx = 26'($urandom);
      spurious = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    instr_ready = 1'b0; spurious = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
